// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, memory-wait stall, branch flush,
// and HLT drain/halt sequencing, plus a saturating counter of stall/flush cycles.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  p0_addr_ID,
    input  logic [3:0]  p1_addr_ID,
    input  logic        uses_p0_ID,
    input  logic        uses_p1_ID,
    input  logic        re_mem_EX,
    input  logic        we_rf_EX,
    input  logic [3:0]  dst_addr_EX,
    input  logic        br_taken_EX,
    input  logic        hlt_ID,
    input  logic        hlt_WB,
    input  logic        mem_req_MEM,
    input  logic        mem_rdy,
    output logic        stall_PC,
    output logic        stall_IFID,
    output logic        stall_IDEX,
    output logic        flush_IDEX,
    output logic        flush_IFID,
    output logic        stall_EXMEM,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DRAIN    = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        ret_drain_q, ret_drain_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        lu_haz, mw_haz, any_act;

    // R0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu_haz = re_mem_EX & we_rf_EX & (dst_addr_EX != 4'd0) &
                    ((uses_p0_ID & (p0_addr_ID == dst_addr_EX)) |
                     (uses_p1_ID & (p1_addr_ID == dst_addr_EX)));
    assign mw_haz = mem_req_MEM & ~mem_rdy;

    assign stall_cnt = stall_cnt_q;

    // Next-state, return-to-drain flag, control outputs and counter update.
    always_comb begin
        state_d     = state_q;
        ret_drain_d = ret_drain_q;
        stall_PC    = 1'b0;
        stall_IFID  = 1'b0;
        stall_IDEX  = 1'b0;
        stall_EXMEM = 1'b0;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        halted      = 1'b0;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_RUN: begin
                if (mw_haz) begin
                    stall_PC    = 1'b1;
                    stall_IFID  = 1'b1;
                    stall_IDEX  = 1'b1;
                    stall_EXMEM = 1'b1;
                    ret_drain_d = 1'b0;
                    state_d     = S_MEM_WAIT;
                end else if (br_taken_EX) begin
                    // Taken branch squashes the wrong path, including any HLT in ID.
                    flush_IFID = 1'b1;
                    flush_IDEX = 1'b1;
                end else if (lu_haz) begin
                    stall_PC   = 1'b1;
                    stall_IFID = 1'b1;
                    flush_IDEX = 1'b1;
                end else if (hlt_ID) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MEM_WAIT: begin
                if (!mem_rdy) begin
                    stall_PC    = 1'b1;
                    stall_IFID  = 1'b1;
                    stall_IDEX  = 1'b1;
                    stall_EXMEM = 1'b1;
                end else if (ret_drain_q) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (mw_haz) begin
                    // The whole pipe freezes; IF/ID is held rather than bubbled.
                    stall_PC    = 1'b1;
                    stall_IFID  = 1'b1;
                    stall_IDEX  = 1'b1;
                    stall_EXMEM = 1'b1;
                    ret_drain_d = 1'b1;
                    state_d     = S_MEM_WAIT;
                end else begin
                    stall_PC   = 1'b1;
                    flush_IFID = 1'b1;
                    if (hlt_WB) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_HALTED: begin
                stall_PC    = 1'b1;
                stall_IFID  = 1'b1;
                stall_IDEX  = 1'b1;
                stall_EXMEM = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_d     = S_RUN;
                ret_drain_d = 1'b0;
            end
        endcase

        if (rst) begin
            stall_PC    = 1'b0;
            stall_IFID  = 1'b0;
            stall_IDEX  = 1'b0;
            stall_EXMEM = 1'b0;
            flush_IFID  = 1'b0;
            flush_IDEX  = 1'b0;
            halted      = 1'b0;
        end else begin
            halted = halted;
        end

        any_act = stall_PC | stall_IFID | stall_IDEX | stall_EXMEM | flush_IFID | flush_IDEX;
        if (any_act && (state_q != S_HALTED) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, return flag and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            ret_drain_q <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            ret_drain_q <= ret_drain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes model-predicted responses,
// a monitor pops and compares them one cycle at a time.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  p0_addr_ID, p1_addr_ID, dst_addr_EX;
    logic        uses_p0_ID, uses_p1_ID, re_mem_EX, we_rf_EX;
    logic        br_taken_EX, hlt_ID, hlt_WB, mem_req_MEM, mem_rdy;
    logic        stall_PC, stall_IFID, stall_IDEX, flush_IDEX, flush_IFID, stall_EXMEM, halted;
    logic [15:0] stall_cnt;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
        .uses_p0_ID(uses_p0_ID), .uses_p1_ID(uses_p1_ID),
        .re_mem_EX(re_mem_EX), .we_rf_EX(we_rf_EX), .dst_addr_EX(dst_addr_EX),
        .br_taken_EX(br_taken_EX), .hlt_ID(hlt_ID), .hlt_WB(hlt_WB),
        .mem_req_MEM(mem_req_MEM), .mem_rdy(mem_rdy),
        .stall_PC(stall_PC), .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX),
        .flush_IDEX(flush_IDEX), .flush_IFID(flush_IFID), .stall_EXMEM(stall_EXMEM),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    // flags = {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX, halted}
    typedef struct packed {
        logic [6:0]  flags;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [6:0] F_NONE   = 7'b0000000;
    localparam logic [6:0] F_STALL4 = 7'b1111000;
    localparam logic [6:0] F_BRANCH = 7'b0000110;
    localparam logic [6:0] F_LOADUS = 7'b1100010;
    localparam logic [6:0] F_DRAIN  = 7'b1000100;
    localparam logic [6:0] F_HALT   = 7'b1111001;

    localparam int M_RUN = 0, M_MEMW = 1, M_DRAIN = 2, M_HALT = 3;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_mode  = M_RUN;
    bit   m_back_to_drain = 1'b0;
    int   m_cnt   = 0;

    // Drive one cycle of inputs, predict the DUT response and advance the model.
    task automatic step(input bit r, input bit [3:0] p0, input bit [3:0] p1,
                        input bit u0, input bit u1, input bit re, input bit we,
                        input bit [3:0] dst, input bit br, input bit hid,
                        input bit hwb, input bit mreq, input bit mrdy);
        bit         mw, lu;
        logic [6:0] f;
        int         nxt;
        exp_t       e;
        @(negedge clk);
        rst = r; p0_addr_ID = p0; p1_addr_ID = p1; uses_p0_ID = u0; uses_p1_ID = u1;
        re_mem_EX = re; we_rf_EX = we; dst_addr_EX = dst; br_taken_EX = br;
        hlt_ID = hid; hlt_WB = hwb; mem_req_MEM = mreq; mem_rdy = mrdy;

        mw  = mreq && !mrdy;
        lu  = re && we && (dst != 4'd0) && ((u0 && p0 == dst) || (u1 && p1 == dst));
        f   = F_NONE;
        nxt = m_mode;
        if (m_mode == M_RUN) begin
            if (mw) begin f = F_STALL4; nxt = M_MEMW; m_back_to_drain = 1'b0; end
            else if (br) f = F_BRANCH;
            else if (lu) f = F_LOADUS;
            else if (hid) nxt = M_DRAIN;
        end else if (m_mode == M_MEMW) begin
            if (!mrdy) f = F_STALL4;
            else nxt = m_back_to_drain ? M_DRAIN : M_RUN;
        end else if (m_mode == M_DRAIN) begin
            if (mw) begin f = F_STALL4; nxt = M_MEMW; m_back_to_drain = 1'b1; end
            else begin f = F_DRAIN; if (hwb) nxt = M_HALT; end
        end else begin
            f = F_HALT;
        end
        if (r) f = F_NONE;

        e.flags = f;
        e.cnt   = 16'(m_cnt);
        sb_q.push_back(e);

        if (r) begin
            m_mode = M_RUN; m_back_to_drain = 1'b0; m_cnt = 0;
        end else begin
            if (f[6:1] != 6'd0 && m_mode != M_HALT && m_cnt < 65535) m_cnt = m_cnt + 1;
            m_mode = nxt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        step(1, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: every cycle the DUT presents a response, check it against the queue head.
    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {stall_PC, stall_IFID, stall_IDEX, stall_EXMEM, flush_IFID, flush_IDEX, halted};
                n_tests++;
                if (got !== e.flags) begin
                    n_fail++;
                    $display("FAIL flags at %0t: got %b expected %b", $time, got, e.flags);
                end
                n_tests++;
                if (stall_cnt !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_cnt at %0t: got %0d expected %0d", $time, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; p0_addr_ID = 4'd0; p1_addr_ID = 4'd0; dst_addr_EX = 4'd0;
        uses_p0_ID = 1'b0; uses_p1_ID = 1'b0; re_mem_EX = 1'b0; we_rf_EX = 1'b0;
        br_taken_EX = 1'b0; hlt_ID = 1'b0; hlt_WB = 1'b0; mem_req_MEM = 1'b0; mem_rdy = 1'b1;
        repeat (2) @(negedge clk);

        do_reset();
        // Load-use on R3 via p0: one bubble cycle, counter ends at 1.
        step(0, 4'd3, 4'd1, 1, 1, 1, 1, 4'd3, 0, 0, 0, 0, 1);
        idle(2);
        // No hazard: destination R0, or p1 matches but is unused.
        step(0, 4'd0, 4'd0, 1, 1, 1, 1, 4'd0, 0, 0, 0, 0, 1);
        step(0, 4'd2, 4'd5, 1, 0, 1, 1, 4'd5, 0, 0, 0, 0, 1);
        // Load-use via p1 only.
        step(0, 4'd2, 4'd5, 0, 1, 1, 1, 4'd5, 0, 0, 0, 0, 1);
        idle(1);
        // Memory wait: three not-ready cycles, then ready.
        repeat (3) step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
        step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1);
        idle(1);
        // Branch + load-use + HLT together: flush only, stay running.
        step(0, 4'd4, 4'd0, 1, 0, 1, 1, 4'd4, 1, 1, 0, 0, 1);
        idle(2);
        // HLT drain, memory wait inside drain, then halt and reset out of it.
        step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 0, 1);
        idle(1);
        step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
        step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1);
        step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 1);
        step(0, 4'd6, 4'd6, 1, 1, 1, 1, 4'd6, 1, 1, 1, 1, 0);
        idle(3);
        do_reset();
        idle(2);

        // Randomized traffic with occasional resets to escape HALTED.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2,
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 60);
        end

        // Saturation: a very long memory wait pins the counter at 16'hFFFF.
        do_reset();
        repeat (70000) step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0);
        step(0, 4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, 1);
        idle(2);

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #3;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses never checked, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
